// File: rtl/amba3_apb_mem_slave_pkg.sv
// +-----------------------------------------------------------------------------+
// | pkg_amba3 : shared types and helpers for the AMBA 3 APB memory slave          |
// | Rev 1.0                                                                       |
// +-----------------------------------------------------------------------------+
`default_nettype none

package pkg_amba3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } st_apb_slave_e;

  // Window test done at 64 bits so an address below base never aliases into range.
  function automatic logic apb_in_range(input logic [63:0] addr,
                                        input logic [63:0] base,
                                        input logic [63:0] bytes);
    return (addr >= base) && ((addr - base) < bytes);
  endfunction

endpackage

`default_nettype wire

// File: rtl/amba3_apb_regmem.sv
// +-----------------------------------------------------------------------------+
// | amba3_apb_regmem : reset-clearable word array, one write port, comb read     |
// | Rev 1.0                                                                       |
// +-----------------------------------------------------------------------------+
`default_nettype none

module amba3_apb_regmem #(
  parameter int DATA_SIZE = 32,
  parameter int MEM_DEPTH = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         we,
  input  logic [$clog2(MEM_DEPTH)-1:0] waddr,
  input  logic [DATA_SIZE-1:0]         wdata,
  input  logic [$clog2(MEM_DEPTH)-1:0] raddr,
  output logic [DATA_SIZE-1:0]         rdata
);

  logic [DATA_SIZE-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

`default_nettype wire

// File: rtl/amba3_apb_mem_slave.sv
// +-----------------------------------------------------------------------------+
// | amba3_apb_mem_slave : APB completer with register memory, PSLVERR decode and  |
// | sticky protocol monitor. Wait states via AMBA3_APB_MEM_SLAVE_WAIT_EN.  Rev 1.0|
// +-----------------------------------------------------------------------------+
`default_nettype none

module amba3_apb_mem_slave
  import pkg_amba3::*;
#(
  parameter int                   ADDR_SIZE   = 32,
  parameter int                   DATA_SIZE   = 32,
  parameter int                   MEM_DEPTH   = 64,
  parameter logic [ADDR_SIZE-1:0] BASE_ADDR   = 'h0000,
  parameter int                   WAIT_CYCLES = 2
) (
  input  logic                 pclk,
  input  logic                 preset,
  input  logic                 psel,
  input  logic                 penable,
  input  logic                 pwrite,
  input  logic [ADDR_SIZE-1:0] paddr,
  input  logic [DATA_SIZE-1:0] pwdata,
  output logic [DATA_SIZE-1:0] prdata,
  output logic                 pready,
  output logic                 pslverr,
  output logic                 proto_err
);

  localparam int BYTE_W    = $clog2(DATA_SIZE / 8);
  localparam int IDX_W     = $clog2(MEM_DEPTH);
  localparam int MEM_BYTES = MEM_DEPTH * DATA_SIZE / 8;

`ifdef AMBA3_APB_MEM_SLAVE_WAIT_EN
  localparam bit         WAIT_ON   = (WAIT_CYCLES > 0);
  localparam logic [3:0] WAIT_INIT = 4'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);
  logic [3:0] cnt;
`else
  // Evaluates false for every legal WAIT_CYCLES: transfers are always zero-wait.
  localparam bit WAIT_ON = (WAIT_CYCLES < 0);
`endif

  st_apb_slave_e state, state_nxt;

  logic [ADDR_SIZE-1:0] lat_addr;
  logic                 lat_write;
  logic [DATA_SIZE-1:0] lat_wdata;
  logic                 lat_ok;
  logic [IDX_W-1:0]     lat_idx;

  logic [ADDR_SIZE-1:0] offset;
  logic [IDX_W-1:0]     dec_idx;
  logic [IDX_W-1:0]     rd_idx;
  logic                 dec_ok;
  logic                 setup;
  logic                 complete;
  logic                 mem_we;
  logic [DATA_SIZE-1:0] mem_rdata;

  logic                 ok_nxt;
  logic                 write_nxt;
  logic                 pready_nxt;
  logic                 pslverr_nxt;
  logic [DATA_SIZE-1:0] prdata_nxt;
  logic                 viol;

  assign setup    = psel & ~penable;
  assign offset   = paddr - BASE_ADDR;
  assign dec_idx  = IDX_W'(offset >> BYTE_W);
  assign dec_ok   = apb_in_range(64'(paddr), 64'(BASE_ADDR), 64'(MEM_BYTES));
  assign complete = (state == RESP) & psel & penable;
  assign mem_we   = complete & lat_write & lat_ok;
  // In IDLE the read port follows the live address so prdata is ready on the RESP entry edge.
  assign rd_idx   = (state == IDLE) ? dec_idx : lat_idx;

  amba3_apb_regmem #(
    .DATA_SIZE (DATA_SIZE),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_regmem (
    .clk   (pclk),
    .rst   (preset),
    .we    (mem_we),
    .waddr (lat_idx),
    .wdata (pwdata),
    .raddr (rd_idx),
    .rdata (mem_rdata)
  );

  always_ff @(posedge pclk) begin
    if (preset) begin
      state     <= IDLE;
      lat_addr  <= '0;
      lat_write <= 1'b0;
      lat_wdata <= '0;
      lat_ok    <= 1'b0;
      lat_idx   <= '0;
      prdata    <= '0;
      pready    <= 1'b0;
      pslverr   <= 1'b0;
      proto_err <= 1'b0;
`ifdef AMBA3_APB_MEM_SLAVE_WAIT_EN
      cnt       <= '0;
`endif
    end else begin
      state     <= state_nxt;
      prdata    <= prdata_nxt;
      pready    <= pready_nxt;
      pslverr   <= pslverr_nxt;
      proto_err <= proto_err | viol;
      if ((state == IDLE) && setup) begin
        lat_addr  <= paddr;
        lat_write <= pwrite;
        lat_wdata <= pwdata;
        lat_ok    <= dec_ok;
        lat_idx   <= dec_idx;
      end
`ifdef AMBA3_APB_MEM_SLAVE_WAIT_EN
      if ((state == IDLE) && setup) begin
        cnt <= WAIT_INIT;
      end else if ((state == WAIT) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (setup) begin
          state_nxt = WAIT_ON ? WAIT : RESP;
        end
      end
`ifdef AMBA3_APB_MEM_SLAVE_WAIT_EN
      WAIT: begin
        if (!psel) begin
          state_nxt = IDLE;
        end else if (cnt == 4'd0) begin
          state_nxt = RESP;
        end
      end
`endif
      RESP: begin
        if (!psel || penable) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ok_nxt      = (state == IDLE) ? dec_ok : lat_ok;
    write_nxt   = (state == IDLE) ? pwrite : lat_write;
    pready_nxt  = (state_nxt == RESP);
    pslverr_nxt = pready_nxt & ~ok_nxt;
    prdata_nxt  = (pready_nxt && ok_nxt && !write_nxt) ? mem_rdata : '0;
    viol        = 1'b0;
    case (state)
      IDLE:       viol = penable;
      WAIT, RESP: viol = ~psel
                       | (paddr != lat_addr)
                       | (pwrite != lat_write)
                       | (lat_write & (pwdata != lat_wdata));
      default:    viol = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_amba3_apb_mem_slave.sv
// +-----------------------------------------------------------------------------+
// | tb_amba3_apb_mem_slave : directed bench for amba3_apb_mem_slave              |
// | Rev 1.0                                                                       |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_amba3_apb_mem_slave;

`ifdef AMBA3_APB_MEM_SLAVE_WAIT_EN
  localparam int EXP_WAITS = 2;
`else
  localparam int EXP_WAITS = 0;
`endif

  logic        pclk = 1'b0;
  logic        preset;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic        proto_err;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  amba3_apb_mem_slave dut (
    .pclk      (pclk),
    .preset    (preset),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr),
    .proto_err (proto_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // One APB transfer; hold keeps psel high so the next call forms a back-to-back setup.
  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input bit hold, output logic [31:0] rdata, output logic err,
                      output int waits);
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = wdata;
    tick();
    penable = 1'b1;
    waits   = 0;
    while (pready !== 1'b1 && waits < 40) begin
      tick();
      waits++;
    end
    if (pready !== 1'b1) check("pready_timeout", 32'(pready), 32'd1);
    rdata = prdata;
    err   = pslverr;
    tick();
    penable = 1'b0;
    if (!hold) psel = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        err;
    int          w;
    int          c0;

    preset  = 1'b1;
    psel    = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    repeat (3) tick();
    check("rst_prdata",    prdata,           32'h0);
    check("rst_pready",    32'(pready),      32'h0);
    check("rst_pslverr",   32'(pslverr),     32'h0);
    check("rst_proto_err", 32'(proto_err),   32'h0);
    preset = 1'b0;
    tick();

    // Basic write then read with wait-state count
    xfer(1'b1, 32'h0040, 32'h80003333, 1'b0, rd, err, w);
    check("t1_wr_err",   32'(err), 32'h0);
    check("t1_wr_waits", 32'(w),   32'(EXP_WAITS));
    xfer(1'b0, 32'h0040, 32'h0, 1'b0, rd, err, w);
    check("t1_rd_data",  rd,       32'h80003333);
    check("t1_rd_err",   32'(err), 32'h0);
    check("t1_rd_waits", 32'(w),   32'(EXP_WAITS));
    check("t1_post_pready",  32'(pready),  32'h0);
    check("t1_post_pslverr", 32'(pslverr), 32'h0);
    check("t1_post_prdata",  prdata,       32'h0);

    // First/last word and out-of-range
    xfer(1'b1, 32'h0000, 32'h11111111, 1'b0, rd, err, w);
    xfer(1'b1, 32'h00FC, 32'hFFFFFFFF, 1'b0, rd, err, w);
    check("t2_wr_last_err", 32'(err), 32'h0);
    xfer(1'b0, 32'h0000, 32'h0, 1'b0, rd, err, w);
    check("t2_rd_first", rd, 32'h11111111);
    check("t2_rd_first_err", 32'(err), 32'h0);
    xfer(1'b0, 32'h00FC, 32'h0, 1'b0, rd, err, w);
    check("t2_rd_last", rd, 32'hFFFFFFFF);
    check("t2_rd_last_err", 32'(err), 32'h0);
    xfer(1'b0, 32'h0100, 32'h0, 1'b0, rd, err, w);
    check("t2_oor_rd_err",  32'(err), 32'h1);
    check("t2_oor_rd_data", rd,       32'h0);
    xfer(1'b1, 32'h0100, 32'hDEADBEEF, 1'b0, rd, err, w);
    check("t2_oor_wr_err",  32'(err), 32'h1);
    xfer(1'b0, 32'h0000, 32'h0, 1'b0, rd, err, w);
    check("t2_first_intact", rd, 32'h11111111);

    // Back-to-back write then read of the same word
    c0 = cyc;
    xfer(1'b1, 32'h0018, 32'h22446688, 1'b1, rd, err, w);
    check("t3_wr_cycles", 32'(cyc - c0), 32'(2 + EXP_WAITS));
    c0 = cyc;
    xfer(1'b0, 32'h0018, 32'h0, 1'b0, rd, err, w);
    check("t3_rd_cycles", 32'(cyc - c0), 32'(2 + EXP_WAITS));
    check("t3_rd_data",   rd,              32'h22446688);
    check("t3_proto_err", 32'(proto_err),  32'h0);

    // Misaligned read hits the containing word
    xfer(1'b1, 32'h0040, 32'h12345678, 1'b0, rd, err, w);
    xfer(1'b0, 32'h0042, 32'h0, 1'b0, rd, err, w);
    check("t4_misaligned", rd, 32'h12345678);
    check("t4_err", 32'(err), 32'h0);

    // penable while idle is a violation, and it sticks
    psel    = 1'b1;
    penable = 1'b1;
    pwrite  = 1'b0;
    paddr   = 32'h0040;
    tick();
    psel    = 1'b0;
    penable = 1'b0;
    check("t5_idle_penable", 32'(proto_err), 32'h1);
    repeat (3) tick();
    check("t5_sticky", 32'(proto_err), 32'h1);

    // Address change during the access phase
    preset = 1'b1;
    tick();
    preset = 1'b0;
    check("t5_cleared", 32'(proto_err), 32'h0);
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = 32'h0040;
    tick();
    penable = 1'b1;
    paddr   = 32'h0044;
    tick();
    check("t5_addr_change", 32'(proto_err), 32'h1);
    psel    = 1'b0;
    penable = 1'b0;
    repeat (2) tick();

    // Reset in the middle of a write drops it and clears the sticky flag
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 32'h0084;
    pwdata  = 32'h40506070;
    tick();
    penable = 1'b1;
    preset  = 1'b1;
    tick();
    check("t6_pready",    32'(pready),    32'h0);
    check("t6_proto_err", 32'(proto_err), 32'h0);
    preset  = 1'b0;
    psel    = 1'b0;
    penable = 1'b0;
    tick();
    xfer(1'b0, 32'h0084, 32'h0, 1'b0, rd, err, w);
    check("t6_dropped_write", rd, 32'h0);
    check("t6_rd_err", 32'(err), 32'h0);
    check("t6_proto_after", 32'(proto_err), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
